// File: rtl/univ_shift_register.sv
// Universal WIDTH-bit register: hold, parallel load, shift, rotate, clear, plus an
// autonomous MSB-first serialise mode with busy/done status.
module univ_shift_register #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  localparam logic [2:0] ModeHold = 3'b000;
  localparam logic [2:0] ModeLoad = 3'b001;
  localparam logic [2:0] ModeShl  = 3'b010;
  localparam logic [2:0] ModeShr  = 3'b011;
  localparam logic [2:0] ModeRol  = 3'b100;
  localparam logic [2:0] ModeRor  = 3'b101;
  localparam logic [2:0] ModeClr  = 3'b110;
  localparam logic [2:0] ModeSer  = 3'b111;

  typedef enum logic {StIdle, StSer} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state: commands are honoured only in idle; serialising shifts every cycle.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          case (mode)
            ModeHold: q_d = q_q;
            ModeLoad: q_d = d;
            ModeShl:  q_d = {q_q[WIDTH-2:0], sin_l};
            ModeShr:  q_d = {sin_r, q_q[WIDTH-1:1]};
            ModeRol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            ModeRor:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            ModeClr:  q_d = '0;
            ModeSer: begin
              q_d     = d;
              cnt_d   = '0;
              state_d = StSer;
            end
          endcase
        end
      end
      StSer: begin
        q_d   = {q_q[WIDTH-2:0], sin_l};
        cnt_d = cnt_q + 1'b1;
        // Final shift: leave busy so a new SER can be taken while done is high.
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      q_q     <= RESET_VALUE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = q_q[WIDTH-1];
  assign busy = (state_q == StSer);
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register: directed plan steps plus random traffic,
// compared cycle by cycle against an arithmetic reference model.
module tb_univ_shift_register;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] q;
  logic         sout;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: register value as an integer, plus a count of serial bits left.
  int m_q;
  int m_left;
  bit m_busy;
  bit m_done;

  univ_shift_register #(
    .WIDTH      (W),
    .RESET_VALUE(RV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q      (q),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q    = int'(RV);
    m_left = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  // One clock edge of the reference model using the currently driven inputs.
  task automatic model_edge();
    m_done = 1'b0;
    if (m_busy) begin
      m_q    = (m_q * 2 + int'(sin_l)) % 256;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (en) begin
      case (mode)
        3'd1: m_q = int'(d);
        3'd2: m_q = (m_q * 2 + int'(sin_l)) % 256;
        3'd3: m_q = m_q / 2 + int'(sin_r) * 128;
        3'd4: m_q = (m_q * 2) % 256 + m_q / 128;
        3'd5: m_q = m_q / 2 + (m_q % 2) * 128;
        3'd6: m_q = 0;
        3'd7: begin
          m_q    = int'(d);
          m_busy = 1'b1;
          m_left = W;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, q, m_q[W-1:0]);
    chk({tag, ".sout"}, {7'd0, sout}, {7'd0, m_q >= 128});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, m_busy});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, m_done});
  endtask

  task automatic step(input string tag, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dd, input logic sl, input logic sr);
    en    = e;
    mode  = m;
    d     = dd;
    sin_l = sl;
    sin_r = sr;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  logic [15:0] bits;
  int          idle_cnt;

  initial begin
    reset_n = 1'b0;
    en = 1'b0; mode = 3'd0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset_n = 1'b1;

    // Asynchronous reset between edges
    step("ld12", 1'b1, 3'd1, 8'h12, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_q", q, 8'hA5);
    chk("async_busy", {7'd0, busy}, 8'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // LOAD / SHL / SHR / en=0
    step("load96", 1'b1, 3'd1, 8'h96, 1'b0, 1'b0);
    chk("load96_k", q, 8'h96);
    step("shl", 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    chk("shl_k", q, 8'h2D);
    step("shr", 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    chk("shr_k", q, 8'h16);
    step("en0", 1'b0, 3'd1, 8'hFF, 1'b1, 1'b1);
    chk("en0_k", q, 8'h16);

    // Rotate and clear
    step("load81", 1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    step("rol", 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    chk("rol_k", q, 8'h03);
    step("ror1", 1'b1, 3'd5, 8'h00, 1'b1, 1'b1);
    chk("ror1_k", q, 8'h81);
    step("ror2", 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    chk("ror2_k", q, 8'hC0);
    step("clr", 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
    chk("clr_k", q, 8'h00);

    // Serialise B4, with an ignored LOAD FF while busy
    bits = '0;
    step("serB4", 1'b1, 3'd7, 8'hB4, 1'b0, 1'b0);
    bits = {bits[14:0], sout};
    for (int i = 1; i < 8; i++) begin
      step("serB4_run", 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
      bits = {bits[14:0], sout};
    end
    chk("serB4_bits", bits[7:0], 8'hB4);
    step("serB4_done", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk("serB4_done_k", {7'd0, done}, 8'h01);
    chk("serB4_end_q", q, 8'h00);
    step("serB4_after", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk("serB4_done_once", {7'd0, done}, 8'h00);

    // Back-to-back: second SER issued in the done cycle
    bits     = '0;
    idle_cnt = 0;
    step("b2b_1", 1'b1, 3'd7, 8'hF0, 1'b0, 1'b0);
    if (busy) bits = {bits[14:0], sout};
    for (int i = 0; i < 8; i++) begin
      step("b2b_run1", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      if (busy) bits = {bits[14:0], sout};
      else idle_cnt++;
    end
    step("b2b_2", 1'b1, 3'd7, 8'h0F, 1'b0, 1'b0);
    if (busy) bits = {bits[14:0], sout};
    for (int i = 0; i < 7; i++) begin
      step("b2b_run2", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      if (busy) bits = {bits[14:0], sout};
      else idle_cnt++;
    end
    chk("b2b_bits_hi", bits[15:8], 8'hF0);
    chk("b2b_bits_lo", bits[7:0], 8'h0F);
    // Only the done cycle itself is not busy.
    chk("b2b_idle", 8'(idle_cnt), 8'd1);
    step("b2b_done", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

    // Reset during shift 4 of a SER
    step("serR", 1'b1, 3'd7, 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("serR_run", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    @(posedge clk);
    #1;
    check_all("midrst_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step("midrst_nodone", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step("midrst_load", 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
    chk("midrst_load_k", q, 8'h3C);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
